int_to_fp32_conv: RTL and testbench

Sequential int-to-float32 converter. It is the encoder that produces IEEE-754 float32 operands for the combinational add/sub FPU ALU, which consumes and decodes them.
- Accepts a signed or unsigned integer over a valid/ready handshake.
- Normalizes iteratively, one left shift per cycle.
- Rounds to nearest, ties to even (RNE).
- Returns the float32 word over a valid/ready output handshake.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/int_to_fp32_conv_if.sv | 37 +++
 rtl/fp32_round_rne.sv | 40 ++++
 rtl/int_to_fp32_conv.sv | 135 +++++++++++++
 tb/tb_int_to_fp32_conv.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared float32 definitions for the FPU family. Holds the
//               IEEE-754 single-precision field widths and bias, the float32
//               word layout shared with the add/sub ALU, and the state
//               encoding of the integer-to-float32 converter.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

  localparam int FP32_BIAS  = 127;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    OUT   = 2'd3
  } conv_state_t;

  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;

endpackage : fpu_pkg
`default_nettype wire

// File: rtl/int_to_fp32_conv_if.sv
`default_nettype none
// ============================================================================
// Module      : int_to_fp32_conv_if
// Description : Input and output handshake bundle of the integer-to-float32
//               converter.
// Ports       : in_valid/in_ready/in_data/in_signed - integer request channel
//               out_valid/out_ready/out_data       - float32 result channel
//               busy                               - converter not idle
//               modport master : producer/consumer side (testbench, host)
//               modport slave  : converter side
// Revision    : 1.0 - initial release
// ============================================================================
interface int_to_fp32_conv_if #(
  parameter int INT_W = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [INT_W-1:0] in_data;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, in_signed, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_signed, out_ready,
    output in_ready, out_valid, out_data, busy
  );

endinterface : int_to_fp32_conv_if
`default_nettype wire

// File: rtl/fp32_round_rne.sv
`default_nettype none
// ============================================================================
// Module      : fp32_round_rne
// Description : Combinational round-to-nearest-even stage for a normalized
//               float32 significand. Handles the mantissa carry-out by
//               clearing the fraction and bumping the exponent.
// Ports       : man_in[23:0] - significand including hidden bit (bit 23)
//               g            - guard bit (first bit below the LSB)
//               s            - sticky bit (OR of all bits below guard)
//               exp_in[7:0]  - biased exponent before rounding
//               exp_out[7:0] - biased exponent after rounding
//               man_out[22:0]- rounded fraction
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_round_rne
  import fpu_pkg::*;
(
  input  wire logic [FP32_MAN_W:0]   man_in,
  input  wire logic                  g,
  input  wire logic                  s,
  input  wire logic [FP32_EXP_W-1:0] exp_in,
  output logic      [FP32_EXP_W-1:0] exp_out,
  output logic      [FP32_MAN_W-1:0] man_out
);

  logic w_round_up;
  logic w_carry;

  // Above half rounds up; exactly half rounds up only from an odd LSB.
  assign w_round_up = g & (s | man_in[0]);

  // With the hidden bit set, an all-ones significand plus one becomes 2.0:
  // the fraction wraps to zero and the exponent absorbs the carry.
  assign w_carry = w_round_up & man_in[FP32_MAN_W] & (&man_in[FP32_MAN_W-1:0]);

  assign man_out = man_in[FP32_MAN_W-1:0] + FP32_MAN_W'(w_round_up);
  assign exp_out = exp_in + FP32_EXP_W'(w_carry);

endmodule : fp32_round_rne
`default_nettype wire

// File: rtl/int_to_fp32_conv.sv
`default_nettype none
// ============================================================================
// Module      : int_to_fp32_conv
// Description : Sequential integer-to-float32 converter. Captures a signed or
//               unsigned integer, normalizes it one left shift per cycle,
//               rounds to nearest-even and presents the float32 word until
//               the consumer accepts it. One conversion in flight.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               bus   - int_to_fp32_conv_if.slave (in_valid, in_ready,
//                       in_data, in_signed, out_valid, out_ready, out_data,
//                       busy)
// Revision    : 1.0 - initial release
// ============================================================================
module int_to_fp32_conv
  import fpu_pkg::*;
#(
  parameter int INT_W = 32
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  int_to_fp32_conv_if.slave  bus
);

  localparam logic [FP32_EXP_W-1:0] C_EXP_INIT = FP32_EXP_W'(FP32_BIAS + INT_W - 1);

  conv_state_t                state;
  logic                       sign_q;
  logic [INT_W-1:0]           mag_q;
  logic [FP32_EXP_W-1:0]      exp_q;
  fp32_t                      out_q;
  logic                       in_ready_q;
  logic                       out_valid_q;
  logic                       busy_q;

  logic                       w_neg;
  logic [INT_W-1:0]           w_mag_in;
  logic                       w_g;
  logic                       w_s;
  logic [FP32_EXP_W-1:0]      w_rnd_exp;
  logic [FP32_MAN_W-1:0]      w_rnd_man;

  // Two's complement negation of the most-negative value yields 2^(INT_W-1),
  // which still fits in INT_W unsigned bits.
  assign w_neg    = bus.in_signed & bus.in_data[INT_W-1];
  assign w_mag_in = w_neg ? (~bus.in_data + INT_W'(1)) : bus.in_data;

  // Guard sits just below the 24-bit significand; sticky covers the rest.
  assign w_g = mag_q[INT_W-25];

  generate
    if (INT_W == 25) begin : g_sticky_none
      assign w_s = 1'b0;
    end else begin : g_sticky_or
      assign w_s = |mag_q[INT_W-26:0];
    end
  endgenerate

  fp32_round_rne u_round (
    .man_in  (mag_q[INT_W-1 -: FP32_MAN_W+1]),
    .g       (w_g),
    .s       (w_s),
    .exp_in  (exp_q),
    .exp_out (w_rnd_exp),
    .man_out (w_rnd_man)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sign_q      <= 1'b0;
      mag_q       <= '0;
      exp_q       <= '0;
      out_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            sign_q     <= w_neg;
            mag_q      <= w_mag_in;
            exp_q      <= C_EXP_INIT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            // Zero has no leading one to find; emit +0 regardless of sign.
            if (w_mag_in == '0) begin
              out_q       <= '0;
              out_valid_q <= 1'b1;
              state       <= OUT;
            end else begin
              state <= NORM;
            end
          end
        end

        NORM: begin
          if (mag_q[INT_W-1]) begin
            state <= ROUND;
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - FP32_EXP_W'(1);
          end
        end

        ROUND: begin
          out_q       <= '{sign: sign_q, exp: w_rnd_exp, man: w_rnd_man};
          out_valid_q <= 1'b1;
          state       <= OUT;
        end

        OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.out_data  = out_q;

endmodule : int_to_fp32_conv
`default_nettype wire

// File: tb/tb_int_to_fp32_conv.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_to_fp32_conv
// Description : Self-checking bench for int_to_fp32_conv (INT_W = 32).
//               Directed vector table, backpressure and reset sequences, and
//               randomized conversions checked against an arithmetic model.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_to_fp32_conv;

  localparam int INT_W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int_to_fp32_conv_if #(.INT_W(INT_W)) bus ();

  int_to_fp32_conv #(.INT_W(INT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] d;
    bit          sgn;
    logic [31:0] f;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: locate the leading one, scale to a 24-bit significand and
  // round the discarded remainder against one half, ties to even.
  function automatic void model(input logic [31:0] d, input bit sgn,
                                output logic [31:0] f, output int lat);
    longint unsigned mag, q, rem, half;
    int p, sh, e;
    bit s;
    s   = sgn && d[31];
    mag = s ? (64'h1_0000_0000 - {32'h0, d}) : {32'h0, d};
    if (mag == 0) begin
      f   = 32'h0;
      lat = 1;
      return;
    end
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    e   = 127 + p;
    lat = (31 - p) + 3;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        e++;
      end
    end
    f = {s, 8'(e), q[22:0]};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) check("in_ready_timeout", bus.in_ready, 32'd1);
  endtask

  // Latency counts the accept edge as cycle 1.
  task automatic convert(input logic [31:0] d, input bit sgn,
                         output logic [31:0] res, output int lat);
    wait_ready();
    bus.in_data   = d;
    bus.in_signed = sgn;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.out_data;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res, exp_f, d;
    int          lat, exp_lat, n, vcount;
    bit          sgn;

    vecs[0]  = '{32'h0000_0001, 1'b1, 32'h3F80_0000, 34};
    vecs[1]  = '{32'hFFFF_FFFF, 1'b1, 32'hBF80_0000, 34};
    vecs[2]  = '{32'h8000_0000, 1'b1, 32'hCF00_0000, 3};
    vecs[3]  = '{32'h8000_0000, 1'b0, 32'h4F00_0000, 3};
    vecs[4]  = '{32'hFFFF_FFFF, 1'b0, 32'h4F80_0000, 3};
    vecs[5]  = '{32'h0100_0001, 1'b1, 32'h4B80_0000, 10};
    vecs[6]  = '{32'h0100_0003, 1'b1, 32'h4B80_0002, 10};
    vecs[7]  = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1};
    vecs[8]  = '{32'h0000_0000, 1'b0, 32'h0000_0000, 1};
    vecs[9]  = '{32'h7FFF_FFFF, 1'b1, 32'h4F00_0000, 4};
    vecs[10] = '{32'hFFFF_FF80, 1'b1, 32'hC300_0000, 27};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_signed = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 32'd1);
    check("rst_out_valid", bus.out_valid, 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_busy", bus.busy, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", bus.in_ready, 32'd1);

    // Directed vectors
    for (int i = 0; i < 11; i++) begin
      convert(vecs[i].d, vecs[i].sgn, res, lat);
      check($sformatf("vec%0d_data", i), res, vecs[i].f);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: result held while out_ready low, input ignored meanwhile
    wait_ready();
    bus.in_data   = 32'h0000_0005;
    bus.in_signed = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_data = 32'h0000_0007;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 6; i++) begin
      check("bp_out_valid", bus.out_valid, 32'd1);
      check("bp_out_data", bus.out_data, 32'h40A0_0000);
      check("bp_in_ready", bus.in_ready, 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_turn_in_ready", bus.in_ready, 32'd1);
    check("bp_turn_out_valid", bus.out_valid, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_next_in_ready", bus.in_ready, 32'd0);
    check("bp_next_busy", bus.busy, 32'd1);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_next_data", bus.out_data, 32'h40E0_0000);
    check("bp_next_latency", 32'(lat), 32'd32);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;

    // Asynchronous reset mid-NORM
    wait_ready();
    bus.in_data   = 32'h0000_0001;
    bus.in_signed = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("pre_rst_busy", bus.busy, 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", bus.in_ready, 32'd1);
    check("arst_out_valid", bus.out_valid, 32'd0);
    check("arst_out_data", bus.out_data, 32'd0);
    check("arst_busy", bus.busy, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) vcount++;
    end
    check("arst_no_stale_valid", 32'(vcount), 32'd0);
    check("arst_release_in_ready", bus.in_ready, 32'd1);

    // Randomized conversions against the model
    for (int i = 0; i < 300; i++) begin
      d   = $urandom >> $urandom_range(0, 31);
      sgn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) d = 32'h0;
      if (sgn && $urandom_range(0, 1) == 1) d = -d;
      model(d, sgn, exp_f, exp_lat);
      convert(d, sgn, res, lat);
      check($sformatf("rand%0d_data d=%08h s=%0d", i, d, sgn), res, exp_f);
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(exp_lat));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_int_to_fp32_conv
`default_nettype wire
